rotate_right: RTL and testbench
===============================

Name: rotate_right

Overview:
Parameterised rotate-right unit for the SHA-256 datapath (Σ/σ functions).
- Combinational output: rotates the input by the compile-time amount ROTATE. This is the primary use in the hash round logic.
- Registered output: rotates a valid-qualified input by a run-time amount through a log-depth barrel rotator, with 1-cycle latency.
- Used wherever the core needs a fixed or variable ROTR.

Parameters:
- WIDTH, 16, data width in bits; legal range ≥1. The SHA-256 core instantiates it with 32.
- ROTATE, 4, fixed rotate-right amount for the combinational output. The effective amount is ROTATE mod WIDTH; any non-negative value is legal.

Ports:
- clk  input  1  clock for the registered path
- rst_n  input  1  asynchronous active-low reset
- in  input  WIDTH  data for the fixed combinational rotate
- out  output  WIDTH  combinational result: ROTR(in, ROTATE mod WIDTH)
- d_valid  input  1  qualifies d and shamt for the registered path
- d  input  WIDTH  data for the variable rotate
- shamt  input  SHW  run-time rotate amount; SHW = max(1, $clog2(WIDTH))
- q_valid  output  1  registered valid
- q  output  WIDTH  registered result: ROTR(d, shamt mod WIDTH)

Behaviour:
- Fixed path (out):
  - Purely combinational; no clock or reset dependency; zero latency.
  - out[i] = in[(i + R) mod WIDTH], where R = ROTATE mod WIDTH.
  - R = 0 gives out = in.
  - Example: WIDTH=16, ROTATE=4, in=16'h1234 gives out=16'h4123.
- Variable path (q, q_valid):
  - Barrel rotator has SHW stages. Stage k rotates right by 2^k when shamt[k]=1; each stage amount is taken mod WIDTH.
  - Result is the rotate of d by shamt mod WIDTH. This also holds when WIDTH is not a power of two and shamt ≥ WIDTH.
- Registers on posedge clk:
  - q_valid <= d_valid.
  - If d_valid=1: q <= rotated d.
  - If d_valid=0: q holds its previous value.
  - Latency is exactly 1 cycle. Throughput is one result per cycle; a new d_valid every cycle is legal.
- Reset:
  - rst_n=0 asynchronously forces q=0 and q_valid=0, independent of clk.
  - Deassertion is synchronous to clk, and is assumed externally synchronised.
  - A transaction in flight when reset asserts is discarded; no output is produced for it.
  - out is unaffected by reset.
- No X propagation from the unused path. The two paths are fully independent.
- WIDTH=1: every rotate is identity and shamt is ignored.

Decomposition:
- Shared package sha_pkg holds:
  - WORD_W = 32
  - SHA-256 rotate constants: ROTR amounts 2, 13, 22, 6, 11, 25, 7, 18, 17, 19
  - function ror_const(data, amt) for elaboration-time use
- One sub-module, barrel_rotr:
  - parameterised on WIDTH; combinational multi-stage rotator
  - instantiated once for the variable path
  - the fixed path uses a constant bit-select/concatenation, not the barrel.

Test Plan:
- WIDTH=16, ROTATE=4, in=16'h1234, wait 10 ns with no clock → out=16'h4123. Then in=16'h8001 → out=16'h1800.
- Assert rst_n=0 between clock edges → q=0 and q_valid=0 immediately. out still tracks in.
- d=16'h1234, shamt=8, d_valid=1 for one cycle → next edge gives q=16'h3412, q_valid=1. Following edge with d_valid=0 gives q_valid=0 and q still 16'h3412.
- Back-to-back over 16 consecutive cycles: d=16'hA5C3, shamt=0..15 → each q equals the software ROTR one cycle later. shamt=0 gives 16'hA5C3.
- WIDTH=32, ROTATE=36 (treated as 4), in=32'h12345678 → out=32'h81234567. WIDTH=12, d=12'hABC, shamt=13 (treated as 1) → q=12'h55E.
- Reset mid-stream: d_valid=1 and rst_n pulsed low before the capturing edge → q=0, q_valid=0. First valid after release is produced normally 1 cycle later.

Source files
------------

// File: rtl/sha_pkg.sv
// Shared SHA-256 constants and helpers for the rotate/shift datapath.
// ROTR amounts are grouped by the hash function that uses them.
package sha_pkg;

    localparam int unsigned WORD_W = 32;

    // Big sigma 0 / big sigma 1 (compression round)
    localparam int unsigned ROTR_BS0_A = 2;
    localparam int unsigned ROTR_BS0_B = 13;
    localparam int unsigned ROTR_BS0_C = 22;
    localparam int unsigned ROTR_BS1_A = 6;
    localparam int unsigned ROTR_BS1_B = 11;
    localparam int unsigned ROTR_BS1_C = 25;

    // Small sigma 0 / small sigma 1 (message schedule)
    localparam int unsigned ROTR_SS0_A = 7;
    localparam int unsigned ROTR_SS0_B = 18;
    localparam int unsigned ROTR_SS1_A = 17;
    localparam int unsigned ROTR_SS1_B = 19;

    // Elaboration-time rotate-right of a full word.
    function automatic logic [WORD_W-1:0] ror_const(input logic [WORD_W-1:0] data,
                                                    input int unsigned amt);
        int unsigned r;
        r = amt % WORD_W;
        if (r == 0) begin
            return data;
        end
        return (data >> r) | (data << (WORD_W - r));
    endfunction

endpackage

// File: rtl/barrel_rotr.sv
// Log-depth combinational rotate-right; stage k rotates by 2^k mod WIDTH,
// so the total rotation is amt mod WIDTH for any WIDTH.
module barrel_rotr
    import sha_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] d_in,
    input  logic [SHW-1:0]   amt,
    output logic [WIDTH-1:0] d_out
);

    logic [WIDTH-1:0] stg [0:SHW];

    assign stg[0] = d_in;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int unsigned AMT = (1 << k) % WIDTH;
        if (AMT == 0) begin : g_pass
            // A multiple of WIDTH is an identity rotation.
            assign stg[k+1] = stg[k];
        end else begin : g_rot
            assign stg[k+1] = amt[k] ? {stg[k][AMT-1:0], stg[k][WIDTH-1:AMT]} : stg[k];
        end
    end

    assign d_out = stg[SHW];

endmodule

// File: rtl/rotate_right.sv
// Rotate-right unit: fixed combinational ROTR by ROTATE, plus a registered
// valid-qualified ROTR by a run-time amount with one cycle of latency.
module rotate_right
    import sha_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ROTATE = 4,
    localparam int unsigned SHW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d,
    input  logic [SHW-1:0]   shamt,
    output logic             q_valid,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned R = ROTATE % WIDTH;

    // Fixed path: pure wiring, independent of clock and reset.
    if (R == 0) begin : g_fix_id
        assign out = in;
    end else begin : g_fix_rot
        assign out = {in[R-1:0], in[WIDTH-1:R]};
    end

    logic [WIDTH-1:0] rot_c;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_d;
    logic             q_valid_q;

    barrel_rotr #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_barrel (
        .d_in  (d),
        .amt   (shamt),
        .d_out (rot_c)
    );

    // Capture a new result only on valid; otherwise hold.
    always_comb begin
        q_d       = q_q;
        q_valid_d = d_valid;
        if (d_valid) begin
            q_d = rot_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;

endmodule

// File: tb/tb_rotate_right.sv
// Scoreboard bench for rotate_right: stimulus pushes expected results,
// monitors pop and compare whenever q_valid is seen.
module tb_rotate_right;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n = 1'b0;

    // Main instance: WIDTH=16, ROTATE=4
    logic [15:0] in16, out16, d16, q16;
    logic [3:0]  sh16;
    logic        v16, qv16;

    // WIDTH=32, ROTATE=36 (fixed path under test)
    logic [31:0] in32, out32, d32, q32;
    logic [4:0]  sh32;
    logic        v32, qv32;

    // WIDTH=12 (non power of two variable path)
    logic [11:0] in12, out12, d12, q12;
    logic [3:0]  sh12;
    logic        v12, qv12;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp16_q[$];
    logic [31:0] exp12_q[$];
    logic [31:0] last16 = '0;
    logic [31:0] last12 = '0;

    always #5 if (clk_en) clk = ~clk;

    rotate_right #(.WIDTH(16), .ROTATE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in(in16), .out(out16),
        .d_valid(v16), .d(d16), .shamt(sh16), .q_valid(qv16), .q(q16)
    );

    rotate_right #(.WIDTH(32), .ROTATE(36)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in(in32), .out(out32),
        .d_valid(v32), .d(d32), .shamt(sh32), .q_valid(qv32), .q(q32)
    );

    rotate_right #(.WIDTH(12), .ROTATE(0)) u_w12 (
        .clk(clk), .rst_n(rst_n), .in(in12), .out(out12),
        .d_valid(v12), .d(d12), .shamt(sh12), .q_valid(qv12), .q(q12)
    );

    // Reference: bit i of the result is bit (i+amt) mod w of the input.
    function automatic logic [31:0] rotr(input logic [31:0] v, input int w, input int amt);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            r[i] = v[(i + amt) % w];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the 16-bit variable path.
    always @(negedge clk) begin
        if (qv16 === 1'b1) begin
            if (exp16_q.size() == 0) begin
                chk("q16_spurious_valid", 32'(qv16), 32'd0);
            end else begin
                last16 = exp16_q.pop_front();
                chk("q16", 32'(q16), last16);
            end
        end else begin
            chk("q16_hold", 32'(q16), last16);
        end
    end

    // Monitor for the 12-bit variable path.
    always @(negedge clk) begin
        if (qv12 === 1'b1) begin
            if (exp12_q.size() == 0) begin
                chk("q12_spurious_valid", 32'(qv12), 32'd0);
            end else begin
                last12 = exp12_q.pop_front();
                chk("q12", 32'(q12), last12);
            end
        end else begin
            chk("q12_hold", 32'(q12), last12);
        end
    end

    task automatic send16(input logic [15:0] dv, input logic [3:0] s, input logic v);
        @(negedge clk);
        d16  = dv;
        sh16 = s;
        v16  = v;
        if (v) exp16_q.push_back(rotr(32'(dv), 16, int'(s)));
    endtask

    task automatic send12(input logic [11:0] dv, input logic [3:0] s, input logic v);
        @(negedge clk);
        d12  = dv;
        sh12 = s;
        v12  = v;
        if (v) exp12_q.push_back(rotr(32'(dv), 12, int'(s)));
    endtask

    initial begin
        in16 = '0; d16 = '0; sh16 = '0; v16 = 1'b0;
        in32 = '0; d32 = '0; sh32 = '0; v32 = 1'b0;
        in12 = '0; d12 = '0; sh12 = '0; v12 = 1'b0;

        // Fixed path with no clock running.
        in16 = 16'h1234;
        #10;
        chk("out16_1234", 32'(out16), 32'h4123);
        in16 = 16'h8001;
        #1;
        chk("out16_8001", 32'(out16), 32'h1800);
        in32 = 32'h12345678;
        #1;
        chk("out32_rot36", out32, 32'h81234567);
        in12 = 12'hABC;
        #1;
        chk("out12_identity", 32'(out12), 32'hABC);
        chk("reset_q16", 32'(q16), 32'd0);
        chk("reset_qv16", 32'(qv16), 32'd0);

        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Single transaction, then an idle cycle to observe hold.
        send16(16'h1234, 4'd8, 1'b1);
        send16(16'h0000, 4'd0, 1'b0);
        send16(16'h0000, 4'd0, 1'b0);

        // Async reset between edges clears outputs immediately.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_q16", 32'(q16), 32'd0);
        chk("async_rst_qv16", 32'(qv16), 32'd0);
        last16 = '0;
        in16 = 16'hBEEF;
        #1;
        chk("out16_in_reset", 32'(out16), 32'hFBEE);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back sweep of every shift amount.
        for (int s = 0; s < 16; s++) begin
            send16(16'hA5C3, 4'(s), 1'b1);
        end
        send16(16'h0000, 4'd0, 1'b0);

        // Reset mid-stream: in-flight transaction is discarded.
        send16(16'h5A5A, 4'd3, 1'b1);
        #2;
        rst_n = 1'b0;
        exp16_q.delete();
        last16 = '0;
        #1;
        chk("midstream_rst_q16", 32'(q16), 32'd0);
        chk("midstream_rst_qv16", 32'(qv16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v16 = 1'b0;
        send16(16'hC001, 4'd1, 1'b1);
        send16(16'h0000, 4'd0, 1'b0);

        // Randomized traffic on the 16-bit path, with random fixed-path checks.
        for (int i = 0; i < 200; i++) begin
            send16(16'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
            in16 = 16'($urandom);
            #1;
            chk("out16_rand", 32'(out16), rotr(32'(in16), 16, 4));
        end
        send16(16'h0000, 4'd0, 1'b0);

        // 12-bit path: shamt >= WIDTH wraps modulo 12.
        send12(12'hABC, 4'd13, 1'b1);
        for (int i = 0; i < 60; i++) begin
            send12(12'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
        end
        send12(12'h000, 4'd0, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("q16_queue_drained", 32'(exp16_q.size()), 32'd0);
        chk("q12_queue_drained", 32'(exp12_q.size()), 32'd0);
        chk("q32_idle_valid", 32'(qv32), 32'd0);
        chk("q32_idle_q", q32, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Explicit check of the documented 12-bit example value.
    initial begin
        wait (qv12 === 1'b1);
        #1;
        chk("q12_ABC_sh13", 32'(q12), 32'h55E);
    end

    // Explicit checks of the documented single-transaction values.
    initial begin
        wait (rst_n === 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("q16_1234_sh8", 32'(q16), 32'h3412);
        chk("qv16_after_valid", 32'(qv16), 32'd1);
        @(posedge clk);
        #1;
        chk("q16_hold_3412", 32'(q16), 32'h3412);
        chk("qv16_after_idle", 32'(qv16), 32'd0);
    end

endmodule
